// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: opcode enumeration and default width.
package alu_pkg;

  localparam int ALU_WIDTH = 16;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } op_e;

endpackage

// File: rtl/alu_addsub.sv
// Combinational WIDTH-bit adder/subtractor sharing one carry chain.
// cout is a borrow when sub=1, so it reads as "A < B unsigned" for subtraction.
module alu_addsub #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ov
);

  logic [WIDTH-1:0] b_eff;
  logic             carry;

  // Subtraction is A + ~B + 1; the raw carry is the inverse of the borrow.
  assign b_eff        = sub ? ~b : b;
  assign {carry, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
  assign cout         = sub ? ~carry : carry;

  // Overflow when the effective operands agree in sign but the sum does not.
  assign ov = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu.sv
// Registered 16-bit ALU execute stage: result and S/Z/P/Cout/Ov flags appear one
// cycle after an enabled capture edge; all outputs reset asynchronously to a C=0 state.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic             S,
  output logic             Z,
  output logic             P,
  output logic             Cout,
  output logic             Ov
);

  function automatic logic even_parity(input logic [WIDTH-1:0] v);
    return ~^v;
  endfunction

  op_e              op;
  logic [WIDTH-1:0] as_sum;
  logic             as_cout;
  logic             as_ov;

  logic [WIDTH-1:0] c_d, c_q;
  logic             s_d, s_q;
  logic             z_d, z_q;
  logic             p_d, p_q;
  logic             cout_d, cout_q;
  logic             ov_d, ov_q;

  assign op = op_e'(Op);

  alu_addsub #(
    .WIDTH(WIDTH)
  ) u_addsub (
    .a   (A),
    .b   (B),
    .sub (op == OP_SUB),
    .sum (as_sum),
    .cout(as_cout),
    .ov  (as_ov)
  );

  always_comb begin
    c_d    = '0;
    cout_d = 1'b0;
    ov_d   = 1'b0;
    unique case (op)
      OP_ADD, OP_SUB: begin
        c_d    = as_sum;
        cout_d = as_cout;
        ov_d   = as_ov;
      end
      OP_AND: c_d = A & B;
      OP_OR:  c_d = A | B;
      OP_XOR: c_d = A ^ B;
      OP_NOT: c_d = ~A;
      OP_SHL: begin
        c_d    = {A[WIDTH-2:0], 1'b0};
        cout_d = A[WIDTH-1];
      end
      OP_SHR: begin
        c_d    = {1'b0, A[WIDTH-1:1]};
        cout_d = A[0];
      end
    endcase
    s_d = c_d[WIDTH-1];
    z_d = (c_d == '0);
    p_d = even_parity(c_d);
  end

  // Output register bank; reset values describe a consistent C=0 result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_q    <= '0;
      s_q    <= 1'b0;
      z_q    <= 1'b1;
      p_q    <= 1'b1;
      cout_q <= 1'b0;
      ov_q   <= 1'b0;
    end else if (en) begin
      c_q    <= c_d;
      s_q    <= s_d;
      z_q    <= z_d;
      p_q    <= p_d;
      cout_q <= cout_d;
      ov_q   <= ov_d;
    end
  end

  assign C    = c_q;
  assign S    = s_q;
  assign Z    = z_q;
  assign P    = p_q;
  assign Cout = cout_q;
  assign Ov   = ov_q;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu: hand-computed vectors, checked 1 ns after each edge.
module tb_alu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic [2:0]  Op  = 3'b000;
  logic [15:0] A   = '0;
  logic [15:0] B   = '0;
  logic [15:0] C;
  logic        S, Z, P, Cout, Ov;

  int n_cmp = 0;
  int n_err = 0;

  alu #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .Op  (Op),
    .A   (A),
    .B   (B),
    .C   (C),
    .S   (S),
    .Z   (Z),
    .P   (P),
    .Cout(Cout),
    .Ov  (Ov)
  );

  always #5 clk = ~clk;

  // Expected layout: {C, S, Z, P, Cout, Ov}
  task automatic chk(input string tag, input logic [15:0] ec, input logic es, ez, ep, eco, eov);
    logic [20:0] obs, exp;
    obs = {C, S, Z, P, Cout, Ov};
    exp = {ec, es, ez, ep, eco, eov};
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed C=%h S=%b Z=%b P=%b Cout=%b Ov=%b expected C=%h S=%b Z=%b P=%b Cout=%b Ov=%b",
             tag, obs[20:5], obs[4], obs[3], obs[2], obs[1], obs[0],
             exp[20:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input logic e);
    @(negedge clk);
    Op = op;
    A  = a;
    B  = b;
    en = e;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Power-on reset
    rst = 1'b1;
    #3;
    chk("reset_initial", 16'h0000, 0, 1, 1, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    en = 1'b1;
    chk("reset_hold_en_ignored", 16'h0000, 0, 1, 1, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // ADD vectors, back to back
    drive(3'b000, 16'h0348, 16'h354e, 1); chk("add_0348_354e", 16'h3896, 0, 0, 0, 0, 0);
    drive(3'b000, 16'h0125, 16'h25fe, 1); chk("add_0125_25fe", 16'h2723, 0, 0, 0, 0, 0);
    drive(3'b000, 16'h34cd, 16'hef12, 1); chk("add_34cd_ef12", 16'h23df, 0, 0, 1, 1, 0);
    drive(3'b000, 16'h7fff, 16'h0001, 1); chk("add_7fff_0001", 16'h8000, 1, 0, 0, 0, 1);
    drive(3'b000, 16'h8000, 16'h8000, 1); chk("add_8000_8000", 16'h0000, 0, 1, 1, 1, 1);

    // SUB
    drive(3'b001, 16'h0000, 16'h0001, 1); chk("sub_0000_0001", 16'hffff, 1, 0, 1, 1, 0);
    drive(3'b001, 16'h8000, 16'h0001, 1); chk("sub_8000_0001", 16'h7fff, 0, 0, 0, 0, 1);

    // Logic and shifts
    drive(3'b010, 16'ha5a5, 16'h0ff0, 1); chk("and", 16'h05a0, 0, 0, 1, 0, 0);
    drive(3'b011, 16'ha5a5, 16'h0ff0, 1); chk("or",  16'haff5, 1, 0, 1, 0, 0);
    drive(3'b100, 16'ha5a5, 16'h0ff0, 1); chk("xor", 16'haa55, 1, 0, 1, 0, 0);
    drive(3'b101, 16'ha5a5, 16'h0ff0, 1); chk("not", 16'h5a5a, 0, 0, 1, 0, 0);
    drive(3'b110, 16'ha5a5, 16'h0ff0, 1); chk("shl", 16'h4b4a, 0, 0, 0, 1, 0);
    drive(3'b111, 16'ha5a5, 16'h0ff0, 1); chk("shr", 16'h52d2, 0, 0, 0, 1, 0);

    // Enable hold: outputs keep the SHR result
    drive(3'b000, 16'h7fff, 16'h0001, 0); chk("hold_cycle1", 16'h52d2, 0, 0, 0, 1, 0);
    drive(3'b001, 16'h0000, 16'h0001, 0); chk("hold_cycle2", 16'h52d2, 0, 0, 0, 1, 0);
    drive(3'b110, 16'hffff, 16'hffff, 0); chk("hold_cycle3", 16'h52d2, 0, 0, 0, 1, 0);
    drive(3'b000, 16'h7fff, 16'h0001, 1); chk("hold_release", 16'h8000, 1, 0, 0, 0, 1);

    // Asynchronous reset mid-stream with C nonzero, away from any edge
    drive(3'b001, 16'h0000, 16'h0001, 1); chk("pre_async_reset", 16'hffff, 1, 0, 1, 1, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_immediate", 16'h0000, 0, 1, 1, 0, 0);
    @(posedge clk);
    #1;
    chk("async_reset_hold", 16'h0000, 0, 1, 1, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(3'b000, 16'h0348, 16'h354e, 1); chk("after_reset_first", 16'h3896, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu.md
# alu

Registered 16-bit arithmetic/logic unit with a status-flag set (sign, zero, parity, carry, overflow). It is the datapath execute stage: operands and opcode are sampled on a clock edge, and result plus flags are presented from registers one cycle later. Addition is opcode 0, so the block defaults to an adder when the opcode is tied low.

## Interface
- WIDTH, 16: operand/result width; flags are defined for any WIDTH ≥ 2.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  capture enable; when low, all outputs hold.
- Op  input  3  operation select (encoding below).
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- C  output  WIDTH  registered result.
- S  output  1  sign: C[WIDTH-1].
- Z  output  1  zero: 1 when C == 0.
- P  output  1  parity: 1 when C has an even number of 1 bits.
- Cout  output  1  carry/borrow/shifted-out bit.
- Ov  output  1  signed (two's-complement) overflow.

## Operation
- Op encoding and result:
  - 000 ADD: C = A + B.
  - 001 SUB: C = A − B.
  - 010 AND: C = A & B.
  - 011 OR: C = A | B.
  - 100 XOR: C = A ^ B.
  - 101 NOT: C = ~A; B ignored.
  - 110 SHL: C = A << 1, LSB filled with 0.
  - 111 SHR: C = A >> 1 (logical), MSB filled with 0.
- Cout rules:
  - ADD: carry out of bit WIDTH-1.
  - SUB: borrow, i.e. 1 when A < B unsigned.
  - SHL: A[WIDTH-1].
  - SHR: A[0].
  - Logic ops: 0.
- Ov rules:
  - ADD: 1 when A and B have equal sign bits and the sign of C differs from them.
  - SUB: 1 when A and B have different sign bits and the sign of C differs from the sign of A.
  - All other ops: 0.
- S, Z and P are computed from the final WIDTH-bit result for every op.
- The result is truncated to WIDTH bits; the only carry information is Cout.

## Timing
- Latency is one cycle. Inputs are sampled at the rising clk edge where en=1, and C plus all flags are valid after that edge.
- en=0: all outputs hold their previous values; no partial updates.
- Reset asserted (asynchronous, at any time, including mid-stream):
  - C=0, S=0, Z=1, P=1, Cout=0, Ov=0. These flags are consistent with C=0.
  - While rst is high, outputs stay at these values and en is ignored.
- Reset deassertion: the first capture occurs on the first rising edge with rst=0 and en=1.
- Back-to-back operations: a new result appears every cycle while en=1. There is no handshake and no stall.
- Outputs never depend combinationally on the inputs.

## Structure
- Package alu_pkg holds:
  - the Op enumeration (OP_ADD … OP_SHR, 3 bits);
  - the default WIDTH constant.
- Sub-module alu_addsub, a combinational WIDTH-bit adder/subtractor:
  - inputs: a, b, sub;
  - outputs: sum, cout (borrow-normalised), ov.
- The top level contains:
  - the op mux;
  - S/Z/P derivation, where P is the XNOR-reduction of the result;
  - the output register bank with asynchronous reset.

## Test plan
- Reset: assert rst mid-operation with C nonzero -> C=0000, S=0, Z=1, P=1, Cout=0, Ov=0 immediately, without waiting for a clock edge.
- ADD vectors, Op=000, en=1, one per cycle. The results must appear one cycle after each input:
  - A=0348, B=354e -> C=3896, S=0, Z=0, P=0, Cout=0, Ov=0.
  - A=0125, B=25fe -> C=2723, P=0, Cout=0, Ov=0.
  - A=34cd, B=ef12 -> C=23df, P=1, Cout=1, Ov=0.
- ADD edge cases:
  - A=7fff, B=0001 -> C=8000, S=1, P=0, Ov=1, Cout=0.
  - A=8000, B=8000 -> C=0000, Z=1, P=1, Cout=1, Ov=1.
- SUB:
  - A=0000, B=0001 -> C=ffff, S=1, P=1, Cout=1, Ov=0.
  - A=8000, B=0001 -> C=7fff, Ov=1, Cout=0.
- Logic and shifts with A=a5a5, B=0ff0:
  - AND -> 05a0.
  - OR -> aff5.
  - XOR -> aa55.
  - NOT -> 5a5a.
  - SHL -> 4b4a, Cout=1.
  - SHR -> 52d2, Cout=1.
  - Ov=0 for all six.
- Enable hold: with en=0, change A, B and Op for 3 cycles -> all outputs are unchanged. When en returns to 1, the next edge produces the new result.
